// File: rtl/spi_engine_offload_sdi_collector_if.sv
// Bundles the SDI byte, SYNC token and DMA word streams of the offload SDI collector.
// Latency: none, signal container only.
// Backpressure: carried by the ready signals; overflow/overflow_clr exist only with SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN.
interface spi_engine_offload_sdi_collector_if #(
    parameter int DATA_W  = 32,
    parameter int LEVEL_W = 5
);
    logic               offload_sdi_valid;
    logic               offload_sdi_ready;
    logic [7:0]         offload_sdi_data;
    logic               sync_valid;
    logic               sync_ready;
    logic [7:0]         sync_data;
    logic               m_valid;
    logic               m_ready;
    logic [DATA_W-1:0]  m_data;
    logic               m_last;
    logic [7:0]         m_sync_id;
    logic [LEVEL_W-1:0] fifo_level;
    logic               sync_empty;
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
    logic               overflow;
    logic               overflow_clr;
`endif

    // Collector side
    modport slave (
        input  offload_sdi_valid, offload_sdi_data, sync_valid, sync_data, m_ready,
        output offload_sdi_ready, sync_ready, m_valid, m_data, m_last, m_sync_id,
               fifo_level, sync_empty
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        , input overflow_clr, output overflow
`endif
    );

    // Engine / DMA side
    modport master (
        output offload_sdi_valid, offload_sdi_data, sync_valid, sync_data, m_ready,
        input  offload_sdi_ready, sync_ready, m_valid, m_data, m_last, m_sync_id,
               fifo_level, sync_empty
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        , output overflow_clr, input overflow
`endif
    );
endinterface

// File: rtl/spi_engine_offload_sdi_collector.sv
// Packs offload SDI bytes MSB-first into words, queued in a FWFT FIFO towards a DMA; SYNC closes a burst.
// Latency: the byte completing a word at edge N gives m_valid after edge N when the FIFO was empty.
// Backpressure: full FIFO parks the word in HOLD and drops both readies; SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN drops it instead.
module spi_engine_offload_sdi_collector #(
    parameter int BYTES_PER_WORD  = 4,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                              spi_clk,
    input  logic                              spi_resetn,
    spi_engine_offload_sdi_collector_if.slave bus
);
    localparam int DW    = 8 * BYTES_PER_WORD;
    localparam int CW    = $clog2(BYTES_PER_WORD + 1);
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

    typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DW-1:0]            word_q, word_d;
    logic                     last_q, last_d;
    logic [7:0]               id_q, id_d;
    logic                     sync_empty_q, sync_empty_d;

    logic                     in_rdy;
    logic                     byte_acc, sync_acc;
    logic                     push_req, push, pop, full, m_vld;
    logic [DW-1:0]            push_word;
    logic                     push_last;
    logic [7:0]               push_id;

    logic [DW-1:0]            mem_data [DEPTH];
    logic                     mem_last [DEPTH];
    logic [7:0]               mem_id   [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]   level_q, level_d;

    // Level never exceeds DEPTH, so its top bit alone means "full"; judged before any same-cycle pop
    assign full  = level_q[FIFO_ADDR_WIDTH];
    assign m_vld = (level_q != '0);
    assign pop   = m_vld & bus.m_ready;
    assign push  = push_req & ~full;

    // Pack state register
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) state_q <= ST_FILL;
        else             state_q <= state_d;
    end

    // Next state: park a word that meets a full FIFO, leave on the first non-full cycle
    always_comb begin
        state_d = state_q;
`ifndef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        if (state_q == ST_FILL && push_req && full) state_d = ST_HOLD;
        else if (state_q == ST_HOLD && !full)       state_d = ST_FILL;
`endif
    end

    // Outputs of the pack FSM: input readiness and the resulting accepts
    always_comb begin
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        in_rdy = 1'b1;
`else
        in_rdy = (state_q == ST_FILL);
`endif
        byte_acc = bus.offload_sdi_valid & in_rdy;
        sync_acc = bus.sync_valid & in_rdy;
    end

    assign bus.offload_sdi_ready = in_rdy;
    assign bus.sync_ready        = in_rdy;

    // Pack datapath: the byte shifts in first, then a same-cycle SYNC closes the (possibly full) word
    always_comb begin
        logic [DW-1:0] shifted;
        int            fill;
        shifted      = word_q;
        fill         = int'(count_q);
        word_d       = word_q;
        count_d      = count_q;
        last_d       = last_q;
        id_d         = id_q;
        push_req     = 1'b0;
        push_word    = word_q;
        push_last    = last_q;
        push_id      = id_q;
        sync_empty_d = 1'b0;
        if (state_q == ST_HOLD) begin
            push_req = 1'b1;
        end else begin
            if (byte_acc) begin
                shifted = (word_q << 8) | DW'(bus.offload_sdi_data);
                fill    = fill + 1;
            end
            word_d  = shifted;
            count_d = CW'(fill);
            if (sync_acc) begin
                if (fill == 0) begin
                    sync_empty_d = 1'b1;
                end else begin
                    // Left-align the partial word; the shift brings in zero padding at the bottom
                    push_req  = 1'b1;
                    push_word = shifted << (8 * (BYTES_PER_WORD - fill));
                    push_last = 1'b1;
                    push_id   = bus.sync_data;
                end
            end else if (fill == BYTES_PER_WORD) begin
                push_req  = 1'b1;
                push_word = shifted;
                push_last = 1'b0;
                push_id   = 8'h00;
            end
        end
        // Any closed word restarts packing; the word registers double as the HOLD buffer
        if (push_req) begin
            count_d = '0;
            word_d  = push_word;
            last_d  = push_last;
            id_d    = push_id;
        end
    end

    // Pack registers and the sync_empty pulse
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            count_q      <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            id_q         <= 8'h00;
            sync_empty_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            word_q       <= word_d;
            last_q       <= last_d;
            id_q         <= id_d;
            sync_empty_q <= sync_empty_d;
        end
    end

    // FIFO occupancy: simultaneous push and pop cancel
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers wrap naturally at the power-of-two depth
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // FIFO storage, not reset: contents are only visible while level is non-zero
    always_ff @(posedge spi_clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= push_word;
            mem_last[wr_ptr_q] <= push_last;
            mem_id[wr_ptr_q]   <= push_id;
        end
    end

    assign bus.m_valid    = m_vld;
    assign bus.m_data     = m_vld ? mem_data[rd_ptr_q] : '0;
    assign bus.m_last     = m_vld ? mem_last[rd_ptr_q] : 1'b0;
    assign bus.m_sync_id  = m_vld ? mem_id[rd_ptr_q]   : 8'h00;
    assign bus.fifo_level = level_q;
    assign bus.sync_empty = sync_empty_q;

`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
    logic ovf_q;

    // Sticky drop flag; a new drop wins over a clear in the same cycle
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn)            ovf_q <= 1'b0;
        else if (push_req && full)  ovf_q <= 1'b1;
        else if (bus.overflow_clr)  ovf_q <= 1'b0;
    end

    assign bus.overflow = ovf_q;
`endif
endmodule

// File: tb/tb_spi_engine_offload_sdi_collector.sv
// Randomised and directed bench for the offload SDI collector against a queue-based byte/word model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: m_ready driven per cycle; the model tracks HOLD or drop behaviour.
module tb_spi_engine_offload_sdi_collector;
    localparam int BPW   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int DW    = 8 * BPW;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [7:0]    id;
    } ent_t;

    logic spi_clk    = 1'b0;
    logic spi_resetn = 1'b0;
    always #5 spi_clk = ~spi_clk;

    spi_engine_offload_sdi_collector_if #(.DATA_W(DW), .LEVEL_W(AW + 1)) bus ();

    spi_engine_offload_sdi_collector #(
        .BYTES_PER_WORD (BPW),
        .FIFO_ADDR_WIDTH(AW)
    ) dut (
        .spi_clk   (spi_clk),
        .spi_resetn(spi_resetn),
        .bus       (bus)
    );

    // Reference model: pending bytes, queued words, parked word, flags
    logic [7:0] m_part[$];
    ent_t       m_fifo[$];
    bit         m_held;
    ent_t       m_hold_e;
    bit         m_sync_empty;
    bit         m_ovf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t pack(input bit last, input logic [7:0] id);
        ent_t e;
        e.data = '0;
        for (int i = 0; i < m_part.size(); i++) e.data[DW-1-8*i -: 8] = m_part[i];
        e.last = last;
        e.id   = last ? id : 8'h00;
        return e;
    endfunction

    task automatic model_reset();
        m_part.delete();
        m_fifo.delete();
        m_held       = 1'b0;
        m_sync_empty = 1'b0;
        m_ovf        = 1'b0;
    endtask

    task automatic compare_all();
        logic [DW-1:0] hd_data = '0;
        logic          hd_last = 1'b0;
        logic [7:0]    hd_id   = 8'h00;
        if (m_fifo.size() != 0) begin
            hd_data = m_fifo[0].data;
            hd_last = m_fifo[0].last;
            hd_id   = m_fifo[0].id;
        end
        check_eq("m_valid",    bus.m_valid, m_fifo.size() != 0);
        check_eq("m_data",     bus.m_data, hd_data);
        check_eq("m_last",     bus.m_last, hd_last);
        check_eq("m_sync_id",  bus.m_sync_id, hd_id);
        check_eq("fifo_level", bus.fifo_level, m_fifo.size());
        check_eq("sync_empty", bus.sync_empty, m_sync_empty);
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        check_eq("sdi_ready",  bus.offload_sdi_ready, 1'b1);
        check_eq("sync_ready", bus.sync_ready, 1'b1);
        check_eq("overflow",   bus.overflow, m_ovf);
`else
        check_eq("sdi_ready",  bus.offload_sdi_ready, !m_held);
        check_eq("sync_ready", bus.sync_ready, !m_held);
`endif
    endtask

    task automatic drive_idle();
        bus.offload_sdi_valid = 1'b0;
        bus.offload_sdi_data  = 8'h00;
        bus.sync_valid        = 1'b0;
        bus.sync_data         = 8'h00;
        bus.m_ready           = 1'b0;
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        bus.overflow_clr      = 1'b0;
`endif
    endtask

    // One clock: drive inputs, advance the model, then sample after the edge
    task automatic step(input bit sv, input logic [7:0] sd, input bit yv, input logic [7:0] yd,
                        input bit mr, input bit clr);
        ent_t e;
        bit   have    = 1'b0;
        bit   full;
        bit   ovf_set = 1'b0;
        bus.offload_sdi_valid = sv;
        bus.offload_sdi_data  = sd;
        bus.sync_valid        = yv;
        bus.sync_data         = yd;
        bus.m_ready           = mr;
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        bus.overflow_clr      = clr;
`endif
        full         = (m_fifo.size() == DEPTH);
        m_sync_empty = 1'b0;
        if (mr && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (m_held) begin
            if (!full) begin
                m_fifo.push_back(m_hold_e);
                m_held = 1'b0;
            end
        end else begin
            if (sv) m_part.push_back(sd);
            if (yv) begin
                if (m_part.size() == 0) m_sync_empty = 1'b1;
                else begin
                    e = pack(1'b1, yd);
                    have = 1'b1;
                end
            end else if (m_part.size() == BPW) begin
                e = pack(1'b0, 8'h00);
                have = 1'b1;
            end
            if (have) begin
                m_part.delete();
                if (!full) m_fifo.push_back(e);
`ifdef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
                else ovf_set = 1'b1;
`else
                else begin
                    m_held   = 1'b1;
                    m_hold_e = e;
                end
`endif
            end
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge spi_clk);
        #1;
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 3; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int k;
        logic [DW-1:0] expw;
        drive_idle();
        model_reset();
        #1;
        compare_all();
        @(posedge spi_clk);
        #1;
        spi_resetn = 1'b1;
        compare_all();

        // Four back-to-back bytes form one word one cycle after the last byte
        step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t1_early_valid", bus.m_valid, 1'b0);
        step(1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t1_valid", bus.m_valid, 1'b1);
        check_eq("t1_data", bus.m_data, 32'h11223344);
        check_eq("t1_last", bus.m_last, 1'b0);
        drain();

        // SYNC after two bytes gives a padded last word; a bare SYNC only pulses sync_empty
        step(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0);
        check_eq("t2_data", bus.m_data, 32'hAABB0000);
        check_eq("t2_last", bus.m_last, 1'b1);
        check_eq("t2_id", bus.m_sync_id, 8'h5A);
        step(1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("t2_sync_empty", bus.sync_empty, 1'b1);
        check_eq("t2_level", bus.fifo_level, 1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t2_pulse_end", bus.sync_empty, 1'b0);
        drain();

        // Fourth byte together with SYNC closes a full word as last
        step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b1, 8'h07, 1'b0, 1'b0);
        check_eq("t4_data", bus.m_data, 32'h01020304);
        check_eq("t4_last", bus.m_last, 1'b1);
        check_eq("t4_id", bus.m_sync_id, 8'h07);
        check_eq("t4_sync_empty", bus.sync_empty, 1'b0);
        check_eq("t4_level", bus.fifo_level, 1);
        drain();

`ifndef SPI_ENGINE_SDI_COLLECTOR_OVERFLOW_EN
        // 20 bytes into a 4-deep FIFO with no reader: fifth word parks in HOLD
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t3_level", bus.fifo_level, 4);
        check_eq("t3_sdi_ready", bus.offload_sdi_ready, 1'b0);
        check_eq("t3_sync_ready", bus.sync_ready, 1'b0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.m_valid && k < 5) begin
                expw = {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
                check_eq("t3_order", bus.m_data, expw);
                k++;
            end
            step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_eq("t3_count", k, 5);
        check_eq("t3_empty", bus.fifo_level, 0);
`else
        // Full FIFO in drop mode: the next word vanishes and overflow sticks until cleared
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b0, 1'b0);
            check_eq("t6_sdi_ready", bus.offload_sdi_ready, 1'b1);
        end
        check_eq("t6_level", bus.fifo_level, 4);
        check_eq("t6_overflow", bus.overflow, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t6_sticky", bus.overflow, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t6_clear", bus.overflow, 1'b0);
        check_eq("t6_head", bus.m_data, 32'h01020304);
        drain();
`endif

        // Reset mid-burst with three words queued and two bytes pending
        for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t5_queued", bus.fifo_level, 3);
        drive_idle();
        spi_resetn = 1'b0;
        #1;
        check_eq("t5_rst_valid", bus.m_valid, 1'b0);
        check_eq("t5_rst_level", bus.fifo_level, 0);
        model_reset();
        @(posedge spi_clk);
        #1;
        spi_resetn = 1'b1;
        compare_all();
        step(1'b1, 8'hC1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hC4, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t5_restart_data", bus.m_data, 32'hC1C2C3C4);
        check_eq("t5_restart_level", bus.fifo_level, 1);
        drain();

        // Random traffic with reader duty cycle changing per segment
        for (int seg = 0; seg < 15; seg++) begin
            int rd_pct;
            rd_pct = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                step(($urandom % 4) != 0, 8'($urandom), ($urandom % 10) == 0, 8'($urandom),
                     $urandom_range(0, 99) < rd_pct, ($urandom % 25) == 0);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
